// File: rtl/alarm_bank.sv
// alarm_bank: multi-slot alarm controller on the 1 Hz time base.
//   NUM_ALARMS independently programmable/armable slots (hours, minutes, armed),
//   a ring timeout of RING_SECONDS edges and a snooze of SNOOZE_MINUTES that may
//   be used MAX_SNOOZE times per ring event.
// Ports:
//   clk_1hz, reset            clock (rising edge) and async active-high reset
//   wr_en/wr_slot/wr_hours/
//   wr_minutes/wr_arm         slot write request
//   snooze, dismiss           user controls, level sampled each edge
//   current_hours/minutes/
//   seconds                   binary time of day from the timekeeping counter
//   armed                     per-slot armed flags
//   ringing, snoozed          FSM state indication
//   ring_slot                 slot of the current/last ring event
//   wr_error                  one-cycle pulse per rejected write
module alarm_bank #(
   parameter int NUM_ALARMS     = 4,
   parameter int IDX_W          = 2,
   parameter int RING_SECONDS   = 60,
   parameter int SNOOZE_MINUTES = 5,
   parameter int MAX_SNOOZE     = 3
) (
   input  logic                  clk_1hz,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [IDX_W-1:0]      wr_slot,
   input  logic [7:0]            wr_hours,
   input  logic [7:0]            wr_minutes,
   input  logic                  wr_arm,
   input  logic                  snooze,
   input  logic                  dismiss,
   input  logic [7:0]            current_hours,
   input  logic [7:0]            current_minutes,
   input  logic [7:0]            current_seconds,
   output logic [NUM_ALARMS-1:0] armed,
   output logic                  ringing,
   output logic                  snoozed,
   output logic [IDX_W-1:0]      ring_slot,
   output logic                  wr_error
);

   typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

   localparam logic [IDX_W:0] SLOT_LIMIT = (IDX_W+1)'(NUM_ALARMS);
   localparam logic [7:0]     RING_INIT  = 8'(RING_SECONDS - 1);
   localparam logic [7:0]     SNZ_MIN    = 8'(SNOOZE_MINUTES);
   localparam logic [3:0]     SNZ_LIMIT  = 4'(MAX_SNOOZE);

   state_t           state, state_next;
   logic [7:0]       slot_hours   [NUM_ALARMS];
   logic [7:0]       slot_minutes [NUM_ALARMS];
   logic [7:0]       ring_cnt, ring_cnt_next;
   logic [3:0]       snooze_cnt, snooze_cnt_next;
   logic [7:0]       snz_h, snz_h_next;
   logic [7:0]       snz_m, snz_m_next;
   logic [IDX_W-1:0] ring_slot_next;

   logic             wr_ok;
   logic             cancel;
   logic             match_any;
   logic [IDX_W-1:0] match_idx;
   logic [7:0]       snz_h_calc, snz_m_calc;
   logic             at_snooze_time;

   assign wr_ok = wr_en && ({1'b0, wr_slot} < SLOT_LIMIT) &&
                  (wr_hours <= 8'd23) && (wr_minutes <= 8'd59);

   // Disarming the slot that owns the current ring event abandons it.
   assign cancel = wr_ok && !wr_arm && (wr_slot == ring_slot) && (state != IDLE);

   assign at_snooze_time = (current_seconds == 8'd0) &&
                           (current_hours == snz_h) && (current_minutes == snz_m);

   // Lowest armed slot whose stored time equals the current minute boundary.
   always_comb begin
      match_any = 1'b0;
      match_idx = '0;
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
         if (!match_any && armed[i] && (current_seconds == 8'd0) &&
             (current_hours == slot_hours[i]) && (current_minutes == slot_minutes[i])) begin
            match_any = 1'b1;
            match_idx = IDX_W'(i);
         end
      end
   end

   // Current time plus the snooze delay, wrapping minutes at 60 and hours at 24.
   always_comb begin
      snz_m_calc = current_minutes + SNZ_MIN;
      snz_h_calc = current_hours;
      if (snz_m_calc >= 8'd60) begin
         snz_m_calc = snz_m_calc - 8'd60;
         snz_h_calc = snz_h_calc + 8'd1;
      end
      if (snz_h_calc >= 8'd24) begin
         snz_h_calc = snz_h_calc - 8'd24;
      end
   end

   always_comb begin
      state_next      = state;
      ring_cnt_next   = ring_cnt;
      snooze_cnt_next = snooze_cnt;
      snz_h_next      = snz_h;
      snz_m_next      = snz_m;
      ring_slot_next  = ring_slot;
      case (state)
         IDLE: begin
            if (match_any) begin
               state_next      = RINGING;
               ring_slot_next  = match_idx;
               ring_cnt_next   = RING_INIT;
               snooze_cnt_next = '0;
            end
         end
         RINGING: begin
            ring_cnt_next = ring_cnt - 8'd1;
            if (dismiss) begin
               state_next = IDLE;
            end else if (snooze && (snooze_cnt < SNZ_LIMIT)) begin
               state_next      = SNOOZED;
               snz_h_next      = snz_h_calc;
               snz_m_next      = snz_m_calc;
               snooze_cnt_next = snooze_cnt + 4'd1;
            end else if (ring_cnt == 8'd0) begin
               state_next = IDLE;
            end
         end
         SNOOZED: begin
            if (dismiss) begin
               state_next = IDLE;
            end else if (at_snooze_time) begin
               state_next    = RINGING;
               ring_cnt_next = RING_INIT;
            end
         end
         default: state_next = IDLE;
      endcase
      if (cancel) begin
         state_next = IDLE;
      end
   end

   always_ff @(posedge clk_1hz or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         ring_cnt   <= '0;
         snooze_cnt <= '0;
         snz_h      <= '0;
         snz_m      <= '0;
         ring_slot  <= '0;
         ringing    <= 1'b0;
         snoozed    <= 1'b0;
         wr_error   <= 1'b0;
      end else begin
         state      <= state_next;
         ring_cnt   <= ring_cnt_next;
         snooze_cnt <= snooze_cnt_next;
         snz_h      <= snz_h_next;
         snz_m      <= snz_m_next;
         ring_slot  <= ring_slot_next;
         ringing    <= (state_next == RINGING);
         snoozed    <= (state_next == SNOOZED);
         wr_error   <= wr_en && !wr_ok;
      end
   end

   always_ff @(posedge clk_1hz or posedge reset) begin
      if (reset) begin
         armed <= '0;
         for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
            slot_hours[i]   <= '0;
            slot_minutes[i] <= '0;
         end
      end else if (wr_ok) begin
         armed[wr_slot]        <= wr_arm;
         slot_hours[wr_slot]   <= wr_hours;
         slot_minutes[wr_slot] <= wr_minutes;
      end
   end

endmodule

// File: tb/tb_alarm_bank.sv
// tb_alarm_bank: directed scenarios plus randomized traffic for alarm_bank,
//   checked every cycle against a time-of-day based reference model.
module tb_alarm_bank;

   localparam int NA = 3;
   localparam int IW = 2;
   localparam int RS = 60;
   localparam int SM = 5;
   localparam int MS = 3;

   logic          clk_1hz = 1'b0;
   logic          reset;
   logic          wr_en;
   logic [IW-1:0] wr_slot;
   logic [7:0]    wr_hours, wr_minutes;
   logic          wr_arm;
   logic          snooze, dismiss;
   logic [7:0]    current_hours, current_minutes, current_seconds;
   logic [NA-1:0] armed;
   logic          ringing, snoozed, wr_error;
   logic [IW-1:0] ring_slot;

   alarm_bank #(
      .NUM_ALARMS(NA), .IDX_W(IW), .RING_SECONDS(RS),
      .SNOOZE_MINUTES(SM), .MAX_SNOOZE(MS)
   ) dut (
      .clk_1hz(clk_1hz), .reset(reset),
      .wr_en(wr_en), .wr_slot(wr_slot), .wr_hours(wr_hours),
      .wr_minutes(wr_minutes), .wr_arm(wr_arm),
      .snooze(snooze), .dismiss(dismiss),
      .current_hours(current_hours), .current_minutes(current_minutes),
      .current_seconds(current_seconds),
      .armed(armed), .ringing(ringing), .snoozed(snoozed),
      .ring_slot(ring_slot), .wr_error(wr_error)
   );

   always #5 clk_1hz = ~clk_1hz;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model: slot table, ring/snooze flags, edges of ringing left,
   // snooze deadline as minute-of-day, snoozes used in this event.
   int mh [NA];
   int mm [NA];
   bit ma [NA];
   bit m_ring, m_snz, m_err;
   int m_left, m_used, m_dead, m_slot;
   int tod;

   function automatic void model_reset();
      for (int i = 0; i < NA; i++) begin
         mh[i] = 0; mm[i] = 0; ma[i] = 0;
      end
      m_ring = 0; m_snz = 0; m_err = 0;
      m_left = 0; m_used = 0; m_dead = 0; m_slot = 0;
   endfunction

   function automatic logic [NA-1:0] m_armed();
      logic [NA-1:0] v;
      for (int i = 0; i < NA; i++) v[i] = ma[i];
      return v;
   endfunction

   function automatic void model_edge();
      int ch, cm, cs, hit;
      bit ok, busy;
      ch = int'(current_hours);
      cm = int'(current_minutes);
      cs = int'(current_seconds);
      ok = wr_en && (int'(wr_slot) < NA) && (int'(wr_hours) <= 23) && (int'(wr_minutes) <= 59);
      hit = -1;
      for (int i = NA - 1; i >= 0; i--)
         if (ma[i] && cs == 0 && ch == mh[i] && cm == mm[i]) hit = i;
      busy = m_ring || m_snz;
      if (m_ring) begin
         if (dismiss) m_ring = 0;
         else if (snooze && m_used < MS) begin
            m_ring = 0; m_snz = 1; m_used++;
            m_dead = (ch * 60 + cm + SM) % 1440;
         end else if (m_left == 1) m_ring = 0;
         else m_left--;
      end else if (m_snz) begin
         if (dismiss) m_snz = 0;
         else if (cs == 0 && ch * 60 + cm == m_dead) begin
            m_snz = 0; m_ring = 1; m_left = RS;
         end
      end else if (hit >= 0) begin
         m_ring = 1; m_slot = hit; m_left = RS; m_used = 0;
      end
      if (busy && ok && !wr_arm && int'(wr_slot) == m_slot) begin
         m_ring = 0; m_snz = 0;
      end
      if (ok) begin
         mh[wr_slot] = int'(wr_hours);
         mm[wr_slot] = int'(wr_minutes);
         ma[wr_slot] = wr_arm;
      end
      m_err = wr_en && !ok;
   endfunction

   task automatic drive_time();
      current_hours   = 8'(tod / 3600);
      current_minutes = 8'((tod / 60) % 60);
      current_seconds = 8'(tod % 60);
   endtask

   task automatic set_time(input int h, input int m, input int s);
      tod = h * 3600 + m * 60 + s;
      drive_time();
   endtask

   task automatic tick();
      @(posedge clk_1hz);
      model_edge();
      #1;
      check("armed",     32'(armed),     32'(m_armed()));
      check("ringing",   32'(ringing),   32'(m_ring));
      check("snoozed",   32'(snoozed),   32'(m_snz));
      check("ring_slot", 32'(ring_slot), 32'(m_slot));
      check("wr_error",  32'(wr_error),  32'(m_err));
      tod = (tod + 1) % 86400;
      drive_time();
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic run_to(input int h, input int m, input int s);
      int target, guard;
      target = h * 3600 + m * 60 + s;
      guard = 0;
      while (tod != target && guard < 90000) begin
         tick();
         guard++;
      end
      if (tod != target) check("run_to_timeout", 32'(tod), 32'(target));
   endtask

   task automatic do_write(input int slot, input int h, input int m, input bit arm);
      wr_en = 1'b1; wr_slot = IW'(slot); wr_hours = 8'(h); wr_minutes = 8'(m); wr_arm = arm;
      tick();
      wr_en = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; wr_en = 0; wr_slot = '0; wr_hours = '0; wr_minutes = '0; wr_arm = 0;
      snooze = 0; dismiss = 0;
      set_time(0, 0, 1);
      model_reset();
      repeat (2) @(posedge clk_1hz);
      #1;
      check("rst_armed",     32'(armed),     0);
      check("rst_ringing",   32'(ringing),   0);
      check("rst_snoozed",   32'(snoozed),   0);
      check("rst_ring_slot", 32'(ring_slot), 0);
      check("rst_wr_error",  32'(wr_error),  0);
      reset = 1'b0;

      // Basic ring with full timeout.
      set_time(7, 0, 0);
      do_write(1, 7, 30, 1);
      set_time(7, 29, 58);
      tick_n(3);
      check("s1_ringing", 32'(ringing), 1);
      check("s1_slot", 32'(ring_slot), 1);
      tick_n(59);
      check("s1_still_ringing", 32'(ringing), 1);
      tick();
      check("s1_timeout", 32'(ringing), 0);
      check("s1_armed", 32'(armed[1]), 1);

      // Two slots on the same minute: lowest index wins, no later ring.
      do_write(1, 7, 30, 0);
      do_write(0, 6, 0, 1);
      do_write(2, 6, 0, 1);
      set_time(5, 59, 59);
      tick_n(2);
      check("s2_slot", 32'(ring_slot), 0);
      dismiss = 1; tick(); dismiss = 0;
      tick_n(70);
      check("s2_no_second", 32'(ringing), 0);
      check("s2_slot_held", 32'(ring_slot), 0);

      // Snooze across midnight, repeated up to the limit.
      do_write(2, 6, 0, 0);
      do_write(0, 23, 58, 1);
      set_time(23, 57, 59);
      tick_n(2);
      check("s3_ring", 32'(ringing), 1);
      run_to(23, 58, 10);
      snooze = 1; tick(); snooze = 0;
      check("s3_snoozed", 32'(snoozed), 1);
      run_to(0, 3, 0);
      tick();
      check("s3_rering", 32'(ringing), 1);
      snooze = 1; tick(); snooze = 0;
      run_to(0, 8, 0); tick();
      check("s3_ring3", 32'(ringing), 1);
      snooze = 1; tick(); snooze = 0;
      run_to(0, 13, 0); tick();
      check("s3_ring4", 32'(ringing), 1);
      snooze = 1; tick(); snooze = 0;
      check("s3_4th_ignored", 32'(ringing), 1);
      check("s3_4th_not_snoozed", 32'(snoozed), 0);
      dismiss = 1; tick(); dismiss = 0;

      // Rejected writes.
      do_write(0, 24, 0, 1);
      check("s4_err_hours", 32'(wr_error), 1);
      tick();
      check("s4_err_pulse", 32'(wr_error), 0);
      do_write(1, 5, 60, 1);
      check("s4_err_min", 32'(wr_error), 1);
      do_write(3, 5, 5, 1);
      check("s4_err_slot", 32'(wr_error), 1);

      // Dismiss beats snooze; disarm of the ring slot cancels a snooze.
      do_write(1, 1, 0, 1);
      set_time(0, 59, 59);
      tick_n(2);
      snooze = 1; dismiss = 1; tick(); snooze = 0; dismiss = 0;
      check("s5_dismiss_wins", 32'(ringing | snoozed), 0);
      set_time(1, 59, 58);
      do_write(1, 2, 0, 1);
      tick_n(2);
      snooze = 1; tick(); snooze = 0;
      check("s5_snoozed", 32'(snoozed), 1);
      tick_n(3);
      do_write(1, 2, 0, 0);
      check("s5_cancel", 32'(snoozed), 0);
      check("s5_disarmed", 32'(armed[1]), 0);

      // Asynchronous reset during a ring.
      do_write(2, 3, 0, 1);
      set_time(2, 59, 59);
      tick_n(2);
      check("s6_ring", 32'(ringing), 1);
      #2 reset = 1'b1;
      #1;
      check("s6_rst_ringing", 32'(ringing), 0);
      check("s6_rst_armed", 32'(armed), 0);
      model_reset();
      reset = 1'b0;

      // Randomized traffic.
      for (int c = 0; c < 4000; c++) begin
         wr_en      = ($urandom % 8) == 0;
         wr_slot    = IW'($urandom % 4);
         wr_hours   = 8'($urandom % 26);
         wr_minutes = 8'($urandom % 62);
         wr_arm     = ($urandom % 4) != 0;
         snooze     = ($urandom % 20) == 0;
         dismiss    = ($urandom % 60) == 0;
         if (($urandom % 120) == 0) begin
            int k;
            k = int'($urandom % NA);
            tod = (mh[k] * 3600 + mm[k] * 60 + 86398) % 86400;
            drive_time();
         end else if (m_snz && ($urandom % 30) == 0) begin
            tod = (m_dead * 60 + 86398) % 86400;
            drive_time();
         end
         tick();
      end
      wr_en = 0; snooze = 0; dismiss = 0;
      tick_n(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alarm_bank.md
# alarm_bank

Parametrised multi-slot alarm controller: NUM_ALARMS independently programmable and armable alarms, a ring timeout, and snooze with a bounded repeat count. Sits beside the timekeeping counter on clk_1hz. Samples current hours/minutes/seconds in binary and drives a single ringing output plus the index of the slot that fired. Successor to the single-slot alarm, which had no snooze, ring duration or multi-slot support.

## Interface
- NUM_ALARMS, 4: number of alarm slots (1..16).
- IDX_W, 2: slot index width; must satisfy 2**IDX_W >= NUM_ALARMS.
- RING_SECONDS, 60: ring duration before auto-stop (1..255).
- SNOOZE_MINUTES, 5: snooze delay (1..59).
- MAX_SNOOZE, 3: snoozes allowed per ring event (0..15).

- clk_1hz  in  1  time-base clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high.
- wr_en  in  1  write request for one slot.
- wr_slot  in  IDX_W  slot to write.
- wr_hours  in  8  alarm hour, binary 0..23.
- wr_minutes  in  8  alarm minute, binary 0..59.
- wr_arm  in  1  armed flag written with the slot.
- snooze  in  1  level, sampled each edge.
- dismiss  in  1  level, sampled each edge.
- current_hours  in  8  time of day, binary.
- current_minutes  in  8  time of day, binary.
- current_seconds  in  8  time of day, binary.
- armed  out  NUM_ALARMS  per-slot armed flags.
- ringing  out  1  high while in RINGING.
- snoozed  out  1  high while in SNOOZED.
- ring_slot  out  IDX_W  slot of the current ring event; holds its value after return to IDLE.
- wr_error  out  1  one-cycle pulse on a rejected write.

## Operation
- Slot storage: hours[8], minutes[8], armed per slot. Reset clears all to 0.
- Write:
  - Accepted when wr_en=1, wr_slot<NUM_ALARMS, wr_hours<=23 and wr_minutes<=59. The slot takes wr_hours, wr_minutes and armed=wr_arm.
  - Any other write with wr_en=1 leaves all slots unchanged and pulses wr_error.
- Match: a slot matches when it is armed, current_seconds==0, current_hours equals the slot hours, and current_minutes equals the slot minutes. Match logic uses slot values before any same-edge write.
- FSM states: IDLE, RINGING, SNOOZED.
- IDLE:
  - On any match, go to RINGING with ring_slot = lowest matching index.
  - Load ring_cnt=RING_SECONDS-1 and clear snooze_cnt to 0.
- RINGING:
  - ring_cnt decrements each edge.
  - dismiss=1: go to IDLE.
  - Otherwise, snooze=1 and snooze_cnt<MAX_SNOOZE: go to SNOOZED. Set snz_h:snz_m = current time + SNOOZE_MINUTES, with minutes wrapping at 60 (carry into hours) and hours wrapping at 24. Increment snooze_cnt.
  - snooze=1 with snooze_cnt==MAX_SNOOZE is ignored.
  - ring_cnt==0 with no dismiss: go to IDLE. The slot stays armed and fires again next day.
- SNOOZED:
  - dismiss=1: go to IDLE.
  - current_seconds==0 and current time equals snz_h:snz_m: go to RINGING and reload ring_cnt. snooze_cnt is kept.
- Priority on the same edge: dismiss > snooze > timeout.
- Slot matches while in RINGING or SNOOZED are dropped, not queued.
- Cancel: an accepted write to slot ring_slot with wr_arm=0 while in RINGING or SNOOZED forces IDLE on the same edge.
- Time inputs are not range-checked. Out-of-range time never matches a valid slot.

## Timing
- All outputs are registered. Reset values: armed=0, ringing=0, snoozed=0, ring_slot=0, wr_error=0. FSM resets to IDLE; ring_cnt, snooze_cnt, snz_h and snz_m reset to 0.
- Reset asserted mid-ring returns to IDLE immediately and clears all slots.
- Latency: match sampled at edge N gives ringing=1 after edge N.
- Ring length: ringing stays high for exactly RING_SECONDS edges without dismiss or snooze.
- dismiss or snooze sampled at edge N drops ringing after edge N.
- A write at edge N is visible on armed after edge N and affects matches from edge N+1.
- wr_error is high for exactly one cycle per rejected request.

## Test plan
- Reset, then write slot 1 = 07:30 armed; drive time 07:30:00 → ringing=1 and ring_slot=1 one edge later; no dismiss → ringing is high for 60 edges, then 0; armed[1] stays 1.
- Slots 0 and 2 both set to 06:00 armed → at 06:00:00 ring_slot=0; a slot 2 ring is not produced later.
- Ring at 23:58:00, snooze at 23:58:10 → snoozed=1; at 00:03:00 ringing=1 again. Repeat snooze: the 4th snooze is ignored with MAX_SNOOZE=3.
- Write wr_hours=24 or wr_minutes=60, or wr_slot=NUM_ALARMS with NUM_ALARMS<2**IDX_W → wr_error pulses once; armed and slot contents unchanged.
- While ringing, assert snooze and dismiss on the same edge → IDLE (dismiss wins). Separately, write ring_slot with wr_arm=0 during SNOOZED → IDLE with armed bit 0.
- Assert reset during RINGING → ringing=0 and armed=0 immediately, without waiting for a clock edge.
